// File: rtl/regfile_dump_sequencer_pkg.sv
// Shared types and constants for the register-file dump sequencer.
package regfile_dump_sequencer_pkg;

  localparam int NBITS = 32;
  localparam int REGS  = 5;
  localparam int NREGS = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_READ  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic is_last_addr(input logic [REGS-1:0] addr);
    return (addr == REGS'(NREGS - 1));
  endfunction

endpackage

// File: rtl/regfile_dump_counter.sv
// Loadable down-counter that saturates at zero; used to time the pipeline drain.
module regfile_dump_counter #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_val;
    end else if (i_en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_zero = (count_q == '0);

endmodule

// File: rtl/regfile_dump_sequencer.sv
// Owns the register-file port: passes WB writes through and, on request, halts
// fetch, drains the pipeline and streams every register to the debug transmitter.
module regfile_dump_sequencer
  import regfile_dump_sequencer_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_WB_RegWrite,
  input  logic [REGS-1:0]  i_WB_Rd,
  input  logic [NBITS-1:0] i_WB_Data,
  input  logic             i_dbg_dump_req,
  input  logic             i_dbg_ready,
  input  logic [NBITS-1:0] i_rf_rdata,
  output logic             o_rf_we,
  output logic [REGS-1:0]  o_rf_waddr,
  output logic [NBITS-1:0] o_rf_wdata,
  output logic [REGS-1:0]  o_rf_raddr,
  output logic             o_halt_fetch,
  output logic [NBITS-1:0] o_dbg_data,
  output logic             o_dbg_valid,
  output logic             o_dbg_last,
  output logic             o_done,
  output logic             o_err
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [REGS-1:0]  addr_q, addr_d;
  logic [NBITS-1:0] hold_q, hold_d;
  logic             err_q, err_d;
  logic             cnt_load, cnt_en, cnt_zero;
  logic             we_s;

  // Register 0 is hard-wired to zero, so its writes never reach the array.
  assign we_s       = i_WB_RegWrite && (i_WB_Rd != '0);
  assign o_rf_we    = we_s;
  assign o_rf_waddr = i_WB_Rd;
  assign o_rf_wdata = i_WB_Data;
  assign o_dbg_data = hold_q;
  assign o_err      = err_q;

  regfile_dump_counter #(.W(CW)) u_drain_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (cnt_load),
    .i_load_val (CW'(DRAIN_CYCLES - 1)),
    .i_en       (cnt_en),
    .o_zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    hold_d       = hold_q;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    o_rf_raddr   = '0;
    o_halt_fetch = 1'b0;
    o_dbg_valid  = 1'b0;
    o_dbg_last   = 1'b0;
    o_done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (i_dbg_dump_req) begin
          state_d  = ST_DRAIN;
          cnt_load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        o_halt_fetch = 1'b1;
        cnt_en       = 1'b1;
        if (cnt_zero) begin
          state_d = ST_READ;
          addr_d  = '0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_READ: begin
        o_halt_fetch = 1'b1;
        o_rf_raddr   = addr_q;
        hold_d       = i_rf_rdata;
        state_d      = ST_SEND;
      end
      ST_SEND: begin
        o_halt_fetch = 1'b1;
        o_rf_raddr   = addr_q;
        o_dbg_valid  = 1'b1;
        o_dbg_last   = is_last_addr(addr_q);
        if (i_dbg_ready) begin
          if (is_last_addr(addr_q)) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + REGS'(1);
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_DONE: begin
        o_halt_fetch = 1'b1;
        o_done       = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A write landing while the array is being read can corrupt the snapshot.
  always_comb begin
    if (we_s && ((state_q == ST_READ) || (state_q == ST_SEND))) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/regfile_dump_sequencer.md
Name: regfile_dump_sequencer

Overview:
- Owns the register-file port that the write-back stage drives.
- During normal execution, pipeline WB writes pass straight through to the register file.
- On a debug dump request it halts instruction fetch and waits for in-flight instructions to retire through WB.
- It then reads all registers in order and streams each word to the debug/UART transmitter with a valid/ready handshake, then releases the pipeline.

Parameters:
NBITS, 32, data word width
REGS, 5, register address width
NREGS, 32, number of registers dumped (addresses 0..NREGS-1)
DRAIN_CYCLES, 4, cycles from fetch halt until the last in-flight instruction has written back

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_reset  in  1  synchronous, active-low reset
i_WB_RegWrite  in  1  write enable from the write-back stage
i_WB_Rd  in  REGS  destination register from the write-back stage
i_WB_Data  in  NBITS  write data from the write-back stage
i_dbg_dump_req  in  1  single-cycle request to start a dump
i_dbg_ready  in  1  transmitter can accept o_dbg_data
i_rf_rdata  in  NBITS  register-file asynchronous read data for o_rf_raddr
o_rf_we  out  1  register-file write enable
o_rf_waddr  out  REGS  register-file write address
o_rf_wdata  out  NBITS  register-file write data
o_rf_raddr  out  REGS  register-file debug read address
o_halt_fetch  out  1  stops PC update and injects bubbles into IF
o_dbg_data  out  NBITS  dumped register word
o_dbg_valid  out  1  o_dbg_data is valid
o_dbg_last  out  1  current word is register NREGS-1
o_done  out  1  one-cycle pulse when the dump completes
o_err  out  1  sticky: a WB write occurred during READ or SEND

Behaviour:
- Reset (i_reset=0 at a clock edge), from any state including mid-dump:
  - state IDLE; drain counter and address counter 0; holding register 0.
  - o_halt_fetch, o_dbg_valid, o_dbg_last, o_done and o_err all 0.
- Write path is combinational and active in every state:
  - o_rf_we = i_WB_RegWrite && (i_WB_Rd != 0).
  - o_rf_waddr = i_WB_Rd; o_rf_wdata = i_WB_Data.
  - Writes to register 0 are suppressed.
- FSM states: IDLE, DRAIN, READ, SEND, DONE.
- IDLE:
  - On i_dbg_dump_req=1, go to DRAIN and load the drain counter with DRAIN_CYCLES-1.
  - i_dbg_dump_req is ignored in every other state.
- DRAIN:
  - o_halt_fetch=1; the counter decrements each cycle.
  - When the counter reaches 0, go to READ with address = 0.
  - WB writes during DRAIN are legal and pass through.
- READ:
  - o_halt_fetch=1; o_rf_raddr = address counter.
  - Capture i_rf_rdata into the holding register; next state is SEND.
  - READ lasts exactly 1 cycle.
- SEND:
  - o_halt_fetch=1; o_dbg_valid=1; o_dbg_data = holding register.
  - o_dbg_last = (address == NREGS-1).
  - Data is held stable while i_dbg_ready=0; no timeout.
  - On valid && ready: if last, go to DONE; otherwise increment the address and go to READ.
- DONE:
  - o_done=1 and o_halt_fetch=1 for exactly 1 cycle, then IDLE.
  - o_halt_fetch drops in the IDLE cycle that follows.
- o_rf_raddr = 0 outside READ/SEND.
- Address counter is REGS bits wide and never wraps: the transition out of SEND on the last word goes to DONE.
- A write and a read of the same register in the same READ cycle return the old value; the register file is write-at-edge with asynchronous read.
- o_err:
  - Set when o_rf_we=1 while in READ or SEND.
  - The write is still performed.
  - Cleared only by reset.
- Latency, request to first o_dbg_valid: DRAIN_CYCLES + 1 + 1 cycles.
- Minimum dump duration with ready held at 1: DRAIN_CYCLES + 2*NREGS + 1 cycles.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=3'd0, DRAIN=3'd1, READ=3'd2, SEND=3'd3, DONE=3'd4.
  - constants NBITS, REGS, NREGS.
- One natural sub-module: regfile_dump_counter, a loadable down-counter used for the drain count.
- The address counter stays inline.

Test Plan:
- Write-path pass-through: with no dump, WB_RegWrite=1, Rd=5, Data=32'hDEADBEEF -> o_rf_we=1, waddr=5, wdata=DEADBEEF the same cycle. With Rd=0 -> o_rf_we=0.
- Full dump, ready tied 1, reg k preloaded with 32'h100+k:
  - o_halt_fetch rises the cycle after the request.
  - First valid appears 6 cycles after the request.
  - 32 words 0x100..0x11F are sent; o_dbg_last is set only on 0x11F.
  - o_done pulses once; o_halt_fetch drops the following cycle.
- Backpressure: i_dbg_ready=0 for 10 cycles on word 7 -> o_dbg_data stays 0x107, valid stays 1 and the address does not advance; the dump resumes normally after ready rises.
- Drain writes: WB write Rd=3, Data=0x55 during DRAIN -> the dumped word for reg 3 is 0x55 and o_err=0. The same write during SEND -> o_err=1 and remains set.
- Reset mid-dump: i_reset=0 for 1 cycle at word 12 -> next cycle state IDLE, halt/valid/err=0. A new request then dumps from reg 0.
- Ignored request: i_dbg_dump_req pulsed during SEND -> no restart; exactly 32 words and one o_done are produced.
